ibex_multdiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for RV32M/RV64M-style cores. It has its own internal adder and a valid/ready request handshake, so it does not share the ALU. Multiplication is slice-based: a full-width operand A times an MUL_W-bit slice of B per cycle. Division is radix-2 restoring, one quotient bit per cycle. All RISC-V corner cases are handled: divide-by-zero and signed overflow.

---
 rtl/ibex_multdiv_iter.sv | 211 +++++++++++++++++++++
 tb/tb_ibex_multdiv_iter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ibex_multdiv_iter
// Iterative multiply/divide unit: slice-based multiplier (MUL_W bits of B per
// cycle) and radix-2 restoring divider, with private adder and request
// handshake. Optional quotient/remainder cache: IBEX_MULTDIV_DIV_CACHE_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ibex_multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int MUL_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             ready_o,
  input  logic [1:0]       operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int N  = WIDTH / MUL_W;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_REM  = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0, ABS = 3'd1, MUL = 3'd2, DIV = 3'd3, FIX = 3'd4, DONE = 3'd5
  } state_t;

  state_t             state;
  logic [1:0]         op;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [MUL_W-1:0]   slice;
  logic [2*WIDTH-1:0] partial;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_result;

`ifdef IBEX_MULTDIV_DIV_CACHE_EN
  logic               cache_valid, hit_q;
  logic [WIDTH-1:0]   c_a, c_b, c_q, c_r, raw_a, raw_b;
  logic [1:0]         c_mode, mode_q;
`endif

  // Datapath: absolute values, multiply partial product, divide step, sign fix
  always_comb begin
    abs_a    = sign_a ? (~a_q + 1'b1) : a_q;
    abs_b    = sign_b ? (~b_q + 1'b1) : b_q;
    slice    = MUL_W'(b_q >> (int'(cnt) * MUL_W));
    partial  = ({{WIDTH{1'b0}}, a_q} * {{(2*WIDTH-MUL_W){1'b0}}, slice})
               << (int'(cnt) * MUL_W);
    trial    = acc[2*WIDTH-1:WIDTH-1];
    diff     = trial - {1'b0, b_q};
    div_next = (trial >= {1'b0, b_q}) ? {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                      : {acc[2*WIDTH-2:0], 1'b0};
    prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    quo_fix  = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = sign_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    case (op)
      OP_MUL:  fix_result = prod_fix[WIDTH-1:0];
      OP_MULH: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV:  fix_result = quo_fix;
      default: fix_result = rem_fix;
    endcase
  end

  // Control FSM with registered handshake outputs and result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      op       <= OP_MUL;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      result_o <= '0;
`ifdef IBEX_MULTDIV_DIV_CACHE_EN
      cache_valid <= 1'b0;
      hit_q    <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_q      <= '0;
      c_r      <= '0;
      c_mode   <= '0;
      raw_a    <= '0;
      raw_b    <= '0;
      mode_q   <= '0;
`endif
    end else if (kill_i && state != IDLE) begin
      // Abort: drop partial results, no completion pulse
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
`ifdef IBEX_MULTDIV_DIV_CACHE_EN
      if (op[1]) cache_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_i && !kill_i) begin
            state   <= ABS;
            op      <= operator_i;
            a_q     <= op_a_i;
            b_q     <= op_b_i;
            sign_a  <= op_a_i[WIDTH-1] & signed_mode_i[0];
            sign_b  <= op_b_i[WIDTH-1] & signed_mode_i[1];
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
`ifdef IBEX_MULTDIV_DIV_CACHE_EN
            raw_a   <= op_a_i;
            raw_b   <= op_b_i;
            mode_q  <= signed_mode_i;
            hit_q   <= cache_valid && operator_i[1] && (op_a_i == c_a) &&
                       (op_b_i == c_b) && (signed_mode_i == c_mode);
`endif
          end
        end
        ABS: begin
          a_q <= abs_a;
          b_q <= abs_b;
          cnt <= '0;
          // Divider keeps {remainder, numerator/quotient} in the accumulator
          acc <= op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
`ifdef IBEX_MULTDIV_DIV_CACHE_EN
          if (hit_q) begin
            state    <= DONE;
            valid_o  <= 1'b1;
            result_o <= op[0] ? c_r : c_q;
          end else
`endif
          if (op[1] && b_q == '0) begin
            state    <= DONE;
            valid_o  <= 1'b1;
            result_o <= op[0] ? a_q : {WIDTH{1'b1}};
`ifdef IBEX_MULTDIV_DIV_CACHE_EN
            cache_valid <= 1'b1;
            c_a    <= raw_a;
            c_b    <= raw_b;
            c_mode <= mode_q;
            c_q    <= {WIDTH{1'b1}};
            c_r    <= a_q;
`endif
          end else begin
            state <= op[1] ? DIV : MUL;
          end
        end
        MUL: begin
          acc <= acc + partial;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= FIX;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state    <= DONE;
          valid_o  <= 1'b1;
          result_o <= fix_result;
`ifdef IBEX_MULTDIV_DIV_CACHE_EN
          if (op[1]) begin
            cache_valid <= 1'b1;
            c_a    <= raw_a;
            c_b    <= raw_b;
            c_mode <= mode_q;
            c_q    <= quo_fix;
            c_r    <= rem_fix;
          end
`endif
        end
        DONE: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibex_multdiv_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ibex_multdiv_iter
// Directed vectors with a scoreboard queue; a monitor checks result and
// latency on every valid_o pulse.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ibex_multdiv_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, kill;
  logic [1:0]  oper, mode;
  logic [31:0] opa, opb;
  logic        ready, valid, busy;
  logic [31:0] result;

  ibex_multdiv_iter #(.WIDTH(32), .MUL_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ready_o(ready),
    .operator_i(oper), .signed_mode_i(mode), .op_a_i(opa), .op_b_i(opb),
    .kill_i(kill), .result_o(result), .valid_o(valid), .busy_o(busy)
  );

  always #5 clk = ~clk;

`ifdef IBEX_MULTDIV_DIV_CACHE_EN
  localparam int RPT_LAT = 1;   // repeated DIV/REM operands hit the cache
`else
  localparam int RPT_LAT = 34;
`endif

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every completion pulse must match the oldest outstanding entry
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid: got result=%08h, required no pulse", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (result !== e.res) begin
          n_bad++;
          $display("FAIL %s result: got %08h, required %08h", e.name, result, e.res);
        end
        n_cmp++;
        if (cyc - e.acc_cyc != e.lat) begin
          n_bad++;
          $display("FAIL %s latency: got %0d, required %0d", e.name, cyc - e.acc_cyc, e.lat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %08h, required %08h", name, got, want);
    end
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (!ready && t < 200) begin @(negedge clk); t++; end
    if (!ready) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: got ready=0, required ready=1", name);
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [1:0] md,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want, input int lat);
    @(negedge clk);
    wait_ready(name);
    req = 1'b1; oper = op; mode = md; opa = a; opb = b;
    sb.push_back('{name, want, lat, cyc + 1});
    @(negedge clk);
    // Scramble inputs after accept; the unit must have latched them
    req = 1'b0; oper = ~op; mode = ~md; opa = ~a; opb = ~b;
    wait_ready(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_c;
    rst_n = 1'b0; req = 1'b0; kill = 1'b0; oper = 2'd0; mode = 2'd0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready",  {31'd0, ready},  32'd1);
    check("reset_valid",  {31'd0, valid},  32'd0);
    check("reset_busy",   {31'd0, busy},   32'd0);
    check("reset_result", result,          32'd0);

    do_op("mul_basic",  2'd0, 2'b00, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 4);
    do_op("mulh_ss",    2'd1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4);
    do_op("mulh_uu",    2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
    do_op("mulhsu",     2'd1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
    do_op("mul_neg",    2'd0, 2'b11, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 4);
    do_op("div_neg",    2'd2, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
    do_op("rem_neg",    2'd3, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, RPT_LAT);
    do_op("div_zero",   2'd2, 2'b00, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    do_op("rem_zero",   2'd3, 2'b00, 32'h0000_0010, 32'h0000_0000, 32'h0000_0010, 1);
    do_op("div_ovf",    2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    do_op("rem_ovf",    2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, RPT_LAT);
    do_op("divu_big",   2'd2, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
    do_op("remu_big",   2'd3, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, RPT_LAT);

    // kill together with req in IDLE must not start anything
    @(negedge clk);
    wait_ready("kill_idle");
    req = 1'b1; kill = 1'b1; oper = 2'd2; mode = 2'b00; opa = 32'd9; opb = 32'd3;
    @(negedge clk);
    req = 1'b0; kill = 1'b0;
    check("kill_idle_ready", {31'd0, ready}, 32'd1);
    check("kill_idle_busy",  {31'd0, busy},  32'd0);

    // kill at edge 10 of a divide: no pulse, idle on the next cycle
    @(negedge clk);
    wait_ready("kill_div");
    req = 1'b1; oper = 2'd2; mode = 2'b00; opa = 32'd100; opb = 32'd7;
    acc_c = cyc + 1;
    @(negedge clk);
    req = 1'b0;
    while (cyc < acc_c + 9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_div_ready", {31'd0, ready}, 32'd1);
    check("kill_div_busy",  {31'd0, busy},  32'd0);
    repeat (40) @(negedge clk);

    do_op("mul_after_kill", 2'd0, 2'b00, 32'd3, 32'd5, 32'h0000_000F, 4);

`ifdef IBEX_MULTDIV_DIV_CACHE_EN
    do_op("cache_div_miss", 2'd2, 2'b00, 32'd100, 32'd7, 32'd14, 34);
    do_op("cache_rem_hit",  2'd3, 2'b00, 32'd100, 32'd7, 32'd2, 1);
    do_op("cache_rem_miss", 2'd3, 2'b00, 32'd100, 32'd8, 32'd4, 34);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
